sample_stream_checker: RTL and testbench

AXI-Stream sink that consumes the two-channel sample stream produced by the data ingress source and checks it.
- Each 32-bit beat carries {ch1[15:0], ch0[15:0]}; both channels must increment by one per accepted beat, and ch1 must track ch0 by a fixed offset.
- The block applies programmable backpressure, counts beats and errors, and captures the first failing beat.
- It terminates the ingress stream in bring-up builds and in the verification bench.

---
 rtl/sample_stream_checker_if.sv | 14 +
 rtl/sample_stream_checker.sv | 156 +++++++++++++++
 tb/tb_sample_stream_checker.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_stream_checker_if.sv
// AXI-Stream style interface carrying the two-channel sample stream.
// The checker reads tvalid/tdata and drives tready; tlast and tuser pass through unused.
interface axi_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/sample_stream_checker.sv
// Sink for the ingress sample stream: applies a rotating backpressure mask, checks that both
// channels count up in lockstep with a fixed offset, counts beats/errors and captures the first bad beat.
module sample_stream_checker #(
  parameter int          DATA_W    = 32,
  parameter logic [15:0] CH_OFFSET = 16'd0,
  parameter int          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_if.slave              s_axi,
  input  logic              enable,
  input  logic              stop_on_err,
  input  logic              clear,
  input  logic [7:0]        ready_pattern,
  output logic [CNT_W-1:0]  word_count,
  output logic [15:0]       err_count,
  output logic              first_err_valid,
  output logic [DATA_W-1:0] first_err_data,
  output logic [CNT_W-1:0]  first_err_index,
  output logic              synced,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [15:0]       exp0_q, exp0_d;
  logic [15:0]       exp1_q, exp1_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic [DATA_W-1:0] first_err_data_q, first_err_data_d;
  logic [CNT_W-1:0]  first_err_index_q, first_err_index_d;

  logic        tready;
  logic        accept;
  logic        beat_err;
  logic [15:0] ch0;
  logic [15:0] ch1;
  logic [15:0] ch_diff;
  logic        unused_sideband;

  assign unused_sideband = s_axi.tlast ^ s_axi.tuser;

  assign ch0     = s_axi.tdata[15:0];
  assign ch1     = s_axi.tdata[31:16];
  assign ch_diff = ch1 - ch0;

  // Gated by rst_n so a beat offered while reset is held is never handshaken.
  assign tready = rst_n && ((state_q == SYNC) || (state_q == CHECK)) && ready_pattern[phase_q];
  assign accept = s_axi.tvalid && tready;
  assign s_axi.tready = tready;

  always_comb begin
    state_d           = state_q;
    phase_d           = phase_q;
    exp0_d            = exp0_q;
    exp1_d            = exp1_q;
    word_count_d      = word_count_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_data_d  = first_err_data_q;
    first_err_index_d = first_err_index_q;
    beat_err          = 1'b0;

    // Clear is applied first so a beat accepted in the same cycle lands on zeroed counters.
    if (clear) begin
      word_count_d      = '0;
      err_count_d       = '0;
      first_err_valid_d = 1'b0;
      first_err_data_d  = '0;
      first_err_index_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SYNC;
          phase_d = '0;
        end
      end
      SYNC: begin
        phase_d = phase_q + 3'd1;
        if (accept) begin
          exp0_d  = ch0 + 16'd1;
          exp1_d  = ch1 + 16'd1;
          state_d = CHECK;
          if (word_count_d != {CNT_W{1'b1}}) word_count_d = word_count_d + 1'b1;
        end
      end
      CHECK: begin
        phase_d = phase_q + 3'd1;
        if (accept) begin
          beat_err = (ch0 != exp0_q) || (ch1 != exp1_q) || (ch_diff != CH_OFFSET);
          if (beat_err) begin
            if (err_count_d != 16'hFFFF) err_count_d = err_count_d + 16'd1;
            if (!first_err_valid_d) begin
              first_err_valid_d = 1'b1;
              first_err_data_d  = s_axi.tdata;
              first_err_index_d = word_count_d;
            end
            if (stop_on_err) state_d = HALT;
          end
          // Always follow the received value so one dropped beat costs exactly one error.
          exp0_d = ch0 + 16'd1;
          exp1_d = ch1 + 16'd1;
          if (word_count_d != {CNT_W{1'b1}}) word_count_d = word_count_d + 1'b1;
        end
      end
      HALT: begin
      end
      default: state_d = IDLE;
    endcase

    if (!enable) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      phase_q           <= '0;
      exp0_q            <= '0;
      exp1_q            <= '0;
      word_count_q      <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_data_q  <= '0;
      first_err_index_q <= '0;
    end else begin
      state_q           <= state_d;
      phase_q           <= phase_d;
      exp0_q            <= exp0_d;
      exp1_q            <= exp1_d;
      word_count_q      <= word_count_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_data_q  <= first_err_data_d;
      first_err_index_q <= first_err_index_d;
    end
  end

  assign word_count      = word_count_q;
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_data  = first_err_data_q;
  assign first_err_index = first_err_index_q;
  assign synced          = (state_q == CHECK);
  assign halted          = (state_q == HALT);

endmodule

// File: tb/tb_sample_stream_checker.sv
// Directed bench for sample_stream_checker: linear sequence of stimulus steps with
// hand-computed expectations checked by immediate assertions.
module tb_sample_stream_checker;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        stop_on_err;
  logic        clear;
  logic [7:0]  ready_pattern;
  logic [31:0] word_count;
  logic [15:0] err_count;
  logic        first_err_valid;
  logic [31:0] first_err_data;
  logic [31:0] first_err_index;
  logic        synced;
  logic        halted;

  int checks;
  int failures;
  int n;

  axi_if #(.DATA_W(32)) s_axi_if ();

  sample_stream_checker #(
    .DATA_W(32),
    .CH_OFFSET(16'd0),
    .CNT_W(32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axi          (s_axi_if.slave),
    .enable         (enable),
    .stop_on_err    (stop_on_err),
    .clear          (clear),
    .ready_pattern  (ready_pattern),
    .word_count     (word_count),
    .err_count      (err_count),
    .first_err_valid(first_err_valid),
    .first_err_data (first_err_data),
    .first_err_index(first_err_index),
    .synced         (synced),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stream input and advance to just after the next rising edge.
  task automatic apply_stimulus(input logic valid, input logic [31:0] data);
    s_axi_if.tvalid = valid;
    s_axi_if.tdata  = data;
    tick();
  endtask

  // Drop to IDLE with a clear, then re-enter SYNC with phase 0.
  task automatic resync();
    s_axi_if.tvalid = 1'b0;
    enable = 1'b0;
    clear  = 1'b1;
    tick();
    enable = 1'b1;
    clear  = 1'b0;
    tick();
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    enable          = 1'b0;
    stop_on_err     = 1'b0;
    clear           = 1'b0;
    ready_pattern   = 8'hFF;
    s_axi_if.tvalid = 1'b0;
    s_axi_if.tdata  = '0;
    s_axi_if.tlast  = 1'b0;
    s_axi_if.tuser  = 1'b0;

    tick();
    tick();
    check_output("reset_tready", s_axi_if.tready, 1'b0);
    check_output("reset_word_count", word_count, 32'd0);
    check_output("reset_err_count", err_count, 16'd0);
    check_output("reset_first_err_valid", first_err_valid, 1'b0);
    check_output("reset_first_err_data", first_err_data, 32'd0);
    check_output("reset_first_err_index", first_err_index, 32'd0);
    check_output("reset_synced", synced, 1'b0);
    check_output("reset_halted", halted, 1'b0);

    rst_n = 1'b1;
    #1;
    check_output("post_reset_tready", s_axi_if.tready, 1'b0);
    enable = 1'b1;
    #1;
    check_output("idle_tready_enable_edge", s_axi_if.tready, 1'b0);
    tick();

    // Basic run: ten in-order beats at full throughput.
    for (int i = 0; i < 10; i++) begin
      s_axi_if.tvalid = 1'b1;
      s_axi_if.tdata  = {i[15:0], i[15:0]};
      #1;
      check_output($sformatf("full_rate_tready_%0d", i), s_axi_if.tready, 1'b1);
      tick();
    end
    s_axi_if.tvalid = 1'b0;
    check_output("basic_word_count", word_count, 32'd10);
    check_output("basic_err_count", err_count, 16'd0);
    check_output("basic_synced", synced, 1'b1);

    // Dropped beat 6: exactly one error, captured with index 6.
    resync();
    check_output("resync_synced_low", synced, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i != 6) apply_stimulus(1'b1, {i[15:0], i[15:0]});
    end
    s_axi_if.tvalid = 1'b0;
    check_output("drop_word_count", word_count, 32'd9);
    check_output("drop_err_count", err_count, 16'd1);
    check_output("drop_first_err_valid", first_err_valid, 1'b1);
    check_output("drop_first_err_data", first_err_data, 32'h0007_0007);
    check_output("drop_first_err_index", first_err_index, 32'd6);

    // Beat accepted in the same cycle enable falls is still processed.
    enable = 1'b0;
    apply_stimulus(1'b1, 32'h000A_000A);
    check_output("disable_last_beat_word_count", word_count, 32'd10);
    check_output("disable_last_beat_err_count", err_count, 16'd1);
    check_output("disable_tready_low", s_axi_if.tready, 1'b0);
    s_axi_if.tvalid = 1'b0;

    // Channel wrap 0xFFFF -> 0x0000 is not an error.
    resync();
    apply_stimulus(1'b1, 32'hFFFE_FFFE);
    apply_stimulus(1'b1, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 32'h0000_0000);
    apply_stimulus(1'b1, 32'h0001_0001);
    s_axi_if.tvalid = 1'b0;
    check_output("wrap_err_count", err_count, 16'd0);
    check_output("wrap_word_count", word_count, 32'd4);
    check_output("wrap_first_err_valid", first_err_valid, 1'b0);

    // Offset-only error: SYNC beat {5,3} is accepted unchecked; {6,4} matches exp but has diff 2.
    resync();
    apply_stimulus(1'b1, 32'h0005_0003);
    check_output("offset_sync_no_error", err_count, 16'd0);
    apply_stimulus(1'b1, 32'h0006_0004);
    s_axi_if.tvalid = 1'b0;
    check_output("offset_err_count", err_count, 16'd1);
    check_output("offset_first_err_data", first_err_data, 32'h0006_0004);
    check_output("offset_first_err_index", first_err_index, 32'd1);

    // stop_on_err: ch1 jumps ahead of ch0, HALT next cycle.
    resync();
    stop_on_err = 1'b1;
    apply_stimulus(1'b1, 32'h0000_0000);
    apply_stimulus(1'b1, 32'h0001_0001);
    apply_stimulus(1'b1, 32'h0002_0002);
    apply_stimulus(1'b1, 32'h0004_0003);
    s_axi_if.tdata = 32'h0005_0005;
    #1;
    check_output("stop_halted", halted, 1'b1);
    check_output("stop_tready", s_axi_if.tready, 1'b0);
    check_output("stop_err_count", err_count, 16'd1);
    check_output("stop_word_count", word_count, 32'd4);
    check_output("stop_first_err_data", first_err_data, 32'h0004_0003);
    check_output("stop_first_err_index", first_err_index, 32'd3);
    apply_stimulus(1'b1, 32'h0005_0005);
    apply_stimulus(1'b1, 32'h0005_0005);
    check_output("halt_holds_word_count", word_count, 32'd4);
    check_output("halt_still_halted", halted, 1'b1);
    enable = 1'b0;
    apply_stimulus(1'b0, 32'h0);
    check_output("halt_exit_halted", halted, 1'b0);
    check_output("halt_exit_synced", synced, 1'b0);
    enable = 1'b1;
    tick();
    apply_stimulus(1'b1, 32'h000A_000A);
    apply_stimulus(1'b1, 32'h000B_000B);
    s_axi_if.tvalid = 1'b0;
    check_output("rearm_err_count", err_count, 16'd1);
    check_output("rearm_word_count", word_count, 32'd6);
    check_output("rearm_synced", synced, 1'b1);
    check_output("rearm_first_err_data", first_err_data, 32'h0004_0003);
    stop_on_err = 1'b0;

    // Backpressure 0x55 from phase 0: ready on even cycles only.
    s_axi_if.tvalid = 1'b0;
    enable = 1'b0;
    clear  = 1'b1;
    tick();
    enable        = 1'b1;
    clear         = 1'b0;
    ready_pattern = 8'h55;
    tick();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      s_axi_if.tvalid = 1'b1;
      s_axi_if.tdata  = {n[15:0], n[15:0]};
      #1;
      check_output($sformatf("pattern55_tready_%0d", i), s_axi_if.tready, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
      if (i % 2 == 0) n++;
    end
    check_output("pattern55_word_count", word_count, 32'd100);
    check_output("pattern55_err_count", err_count, 16'd0);

    // All-zero mask stalls indefinitely.
    ready_pattern = 8'h00;
    for (int i = 0; i < 3; i++) begin
      s_axi_if.tdata = {n[15:0], n[15:0]};
      #1;
      check_output($sformatf("stall_tready_%0d", i), s_axi_if.tready, 1'b0);
      tick();
    end
    check_output("stall_word_count", word_count, 32'd100);

    // Reset mid-stream with tvalid held high.
    ready_pattern = 8'hFF;
    rst_n = 1'b0;
    #1;
    check_output("midreset_tready_cycle0", s_axi_if.tready, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check_output("midreset_tready_cycle1", s_axi_if.tready, 1'b0);
    check_output("midreset_word_count", word_count, 32'd0);
    check_output("midreset_err_count", err_count, 16'd0);
    check_output("midreset_first_err_valid", first_err_valid, 1'b0);
    check_output("midreset_first_err_data", first_err_data, 32'd0);
    check_output("midreset_first_err_index", first_err_index, 32'd0);
    check_output("midreset_synced", synced, 1'b0);
    check_output("midreset_halted", halted, 1'b0);
    s_axi_if.tvalid = 1'b0;
    tick();

    // Clear and an erroring beat in the same cycle: counters restart from the beat.
    apply_stimulus(1'b1, 32'h0000_0000);
    apply_stimulus(1'b1, 32'h0001_0001);
    check_output("preclear_word_count", word_count, 32'd2);
    clear = 1'b1;
    apply_stimulus(1'b1, 32'h0009_0009);
    clear = 1'b0;
    s_axi_if.tvalid = 1'b0;
    check_output("clear_accept_word_count", word_count, 32'd1);
    check_output("clear_accept_err_count", err_count, 16'd1);
    check_output("clear_accept_first_err_valid", first_err_valid, 1'b1);
    check_output("clear_accept_first_err_index", first_err_index, 32'd0);
    check_output("clear_accept_first_err_data", first_err_data, 32'h0009_0009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
